// File: rtl/rx_decimator.sv
// Decimating I/Q accumulator: sums R signed samples per channel and queues
// each {Q_sum, I_sum} word in a show-ahead FIFO drained over AXI-stream.
module rx_decimator #(
    parameter int RATE_W       = 12,
    parameter int ACC_W        = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int DEFAULT_RATE = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   rate_axis_tdata_i,
    input  logic                          rate_axis_tvalid_i,
    input  logic [31:0]                   dds_iq_axis_tdata_i,
    input  logic                          dds_iq_axis_tvalid_i,
    output logic [2*ACC_W-1:0]            axis_tdata_o,
    output logic                          axis_tvalid_o,
    input  logic                          axis_tready_i,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {ACCUM = 1'b0} state_t;

    state_t                 state, state_next;
    logic [RATE_W-1:0]      rate_reg;
    logic [RATE_W-1:0]      cnt, cnt_next;
    logic [ACC_W-1:0]       acc_i, acc_q, acc_i_next, acc_q_next;
    logic [ACC_W-1:0]       s_i, s_q;
    logic [RATE_W-1:0]      new_rate, eff_rate, new_eff_rate;
    logic                   push;
    logic [2*ACC_W-1:0]     push_word;

    logic [2*ACC_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   overflow;
    logic                   pop, full, wr_en;

    generate
        if (RATE_W < 16) begin : g_unused
            logic unused_rate_bits;
            assign unused_rate_bits = ^rate_axis_tdata_i[15:RATE_W];
        end
    endgenerate

    assign s_i = {{(ACC_W-16){dds_iq_axis_tdata_i[15]}}, dds_iq_axis_tdata_i[15:0]};
    assign s_q = {{(ACC_W-16){dds_iq_axis_tdata_i[31]}}, dds_iq_axis_tdata_i[31:16]};

    // A programmed rate of 0 is treated as 1 (every sample emits a word).
    assign new_rate     = rate_axis_tdata_i[RATE_W-1:0];
    assign eff_rate     = (rate_reg == '0) ? RATE_W'(1) : rate_reg;
    assign new_eff_rate = (new_rate == '0) ? RATE_W'(1) : new_rate;

    always_comb begin
        state_next = state;
        acc_i_next = acc_i;
        acc_q_next = acc_q;
        cnt_next   = cnt;
        push       = 1'b0;
        push_word  = '0;
        case (state)
            ACCUM: begin
                if (rate_axis_tvalid_i) begin
                    // Rate load restarts the block; a same-cycle sample opens the new one.
                    acc_i_next = '0;
                    acc_q_next = '0;
                    cnt_next   = '0;
                    if (dds_iq_axis_tvalid_i) begin
                        if (new_eff_rate == RATE_W'(1)) begin
                            push      = 1'b1;
                            push_word = {s_q, s_i};
                        end else begin
                            acc_i_next = s_i;
                            acc_q_next = s_q;
                            cnt_next   = RATE_W'(1);
                        end
                    end
                end else if (dds_iq_axis_tvalid_i) begin
                    if (cnt == eff_rate - RATE_W'(1)) begin
                        push       = 1'b1;
                        push_word  = {acc_q + s_q, acc_i + s_i};
                        acc_i_next = '0;
                        acc_q_next = '0;
                        cnt_next   = '0;
                    end else begin
                        acc_i_next = acc_i + s_i;
                        acc_q_next = acc_q + s_q;
                        cnt_next   = cnt + RATE_W'(1);
                    end
                end
                state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign pop   = axis_tvalid_o && axis_tready_i;
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            rate_reg <= RATE_W'(DEFAULT_RATE);
            acc_i    <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (rate_axis_tvalid_i) begin
                rate_reg <= new_rate;
            end
            acc_i <= acc_i_next;
            acc_q <= acc_q_next;
            cnt   <= cnt_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!wr_en && pop) begin
                level <= level - LVL_W'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

    assign axis_tvalid_o = (level != '0);
    assign axis_tdata_o  = axis_tvalid_o ? mem[rd_ptr] : '0;
    assign overflow_o    = overflow;
    assign fifo_level_o  = level;

endmodule

// File: tb/tb_rx_decimator.sv
// Bench for rx_decimator: directed scenarios plus random traffic, checked every
// cycle against a block-list / word-queue model of the decimator.
module tb_rx_decimator;

    logic        clk;
    logic        rst;
    logic [15:0] rate_axis_tdata_i;
    logic        rate_axis_tvalid_i;
    logic [31:0] dds_iq_axis_tdata_i;
    logic        dds_iq_axis_tvalid_i;
    logic [63:0] axis_tdata_o;
    logic        axis_tvalid_o;
    logic        axis_tready_i;
    logic        overflow_o;
    logic [4:0]  fifo_level_o;

    rx_decimator dut (
        .clk                  (clk),
        .rst                  (rst),
        .rate_axis_tdata_i    (rate_axis_tdata_i),
        .rate_axis_tvalid_i   (rate_axis_tvalid_i),
        .dds_iq_axis_tdata_i  (dds_iq_axis_tdata_i),
        .dds_iq_axis_tvalid_i (dds_iq_axis_tvalid_i),
        .axis_tdata_o         (axis_tdata_o),
        .axis_tvalid_o        (axis_tvalid_o),
        .axis_tready_i        (axis_tready_i),
        .overflow_o           (overflow_o),
        .fifo_level_o         (fifo_level_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Samples of the open block are kept as a list and summed when the block fills.
    logic [63:0] exp_q[$];
    int          blk_i[$];
    int          blk_q[$];
    int          m_rate;
    bit          m_ovf;
    bit          model_live = 0;
    bit          m_pop;
    bit          m_push;
    logic [63:0] m_word;
    longint      sum_i, sum_q;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            blk_i.delete();
            blk_q.delete();
            m_rate = 10;
            m_ovf  = 0;
        end else begin
            m_pop  = (exp_q.size() > 0) && axis_tready_i;
            m_push = 0;
            if (rate_axis_tvalid_i) begin
                m_rate = int'(rate_axis_tdata_i[11:0]);
                blk_i.delete();
                blk_q.delete();
            end
            if (dds_iq_axis_tvalid_i) begin
                blk_i.push_back(int'($signed(dds_iq_axis_tdata_i[15:0])));
                blk_q.push_back(int'($signed(dds_iq_axis_tdata_i[31:16])));
                if (blk_i.size() == ((m_rate == 0) ? 1 : m_rate)) begin
                    sum_i = 0;
                    sum_q = 0;
                    foreach (blk_i[k]) sum_i += blk_i[k];
                    foreach (blk_q[k]) sum_q += blk_q[k];
                    m_word = {sum_q[31:0], sum_i[31:0]};
                    m_push = 1;
                    blk_i.delete();
                    blk_q.delete();
                end
            end
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                if (exp_q.size() < 16) exp_q.push_back(m_word);
                else m_ovf = 1;
            end
        end
        model_live = 1;
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("tvalid", 64'(axis_tvalid_o), 64'(exp_q.size() != 0));
            chk("tdata", axis_tdata_o, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
            chk("level", 64'(fifo_level_o), 64'(exp_q.size()));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit rl, input logic [15:0] rd, input bit sv,
                        input logic [15:0] si, input logic [15:0] sq, input bit rdy);
        rst                  = 1'b0;
        rate_axis_tvalid_i   = rl;
        rate_axis_tdata_i    = rd;
        dds_iq_axis_tvalid_i = sv;
        dds_iq_axis_tdata_i  = {sq, si};
        axis_tready_i        = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        rate_axis_tvalid_i   = 1'b0;
        rate_axis_tdata_i    = '0;
        dds_iq_axis_tvalid_i = 1'b0;
        dds_iq_axis_tdata_i  = '0;
        axis_tready_i        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, 16'd0, 0, 16'd0, 16'd0, rdy);
    endtask

    logic [31:0] exp_isum;

    initial begin
        do_reset();
        chk("reset_tvalid", 64'(axis_tvalid_o), 64'd0);
        chk("reset_tdata", axis_tdata_o, 64'd0);

        // Rate 4: I=1..4, Q=-1..-4 -> I=10, Q=-10
        step(1, 16'd4, 0, 16'd0, 16'd0, 0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) chk("t1_before", 64'(axis_tvalid_o), 64'd0);
            step(0, 16'd0, 1, 16'(k), 16'(-k), 0);
        end
        chk("t1_word", axis_tdata_o, 64'hFFFFFFF6_0000000A);
        idle(2, 1);

        // Rate 1 and rate 0 both emit per sample
        step(1, 16'd1, 1, 16'h8000, 16'h7FFF, 0);
        chk("t2_word", axis_tdata_o, 64'h00007FFF_FFFF8000);
        step(1, 16'd0, 1, 16'h8000, 16'h7FFF, 0);
        chk("t2_level", 64'(fifo_level_o), 64'd2);
        idle(3, 1);

        // Overflow on the 17th word, then drain in order
        do_reset();
        for (int k = 1; k <= 17; k++) step(k == 1, 16'd1, 1, 16'(k), 16'(-k), 0);
        chk("t3_level", 64'(fifo_level_o), 64'd16);
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        chk("t3_head", axis_tdata_o, 64'hFFFFFFFF_00000001);
        idle(18, 1);
        chk("t3_ovf_sticky", 64'(overflow_o), 64'd1);

        // Rate change mid-block discards the partial sum
        do_reset();
        step(1, 16'd4, 0, 16'd0, 16'd0, 0);
        step(0, 16'd0, 1, 16'd5, 16'd6, 0);
        step(0, 16'd0, 1, 16'd7, 16'd8, 0);
        step(1, 16'd2, 1, 16'd100, 16'(-7), 0);
        chk("t4_none", 64'(fifo_level_o), 64'd0);
        step(0, 16'd0, 1, 16'd23, 16'd3, 0);
        chk("t4_word", axis_tdata_o, 64'hFFFFFFFC_0000007B);
        chk("t4_level", 64'(fifo_level_o), 64'd1);
        idle(2, 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int k = 1; k <= 16; k++) step(k == 1, 16'd1, 1, 16'(k), 16'd0, 0);
        step(0, 16'd0, 1, 16'd99, 16'd0, 1);
        chk("t5_level", 64'(fifo_level_o), 64'd16);
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        chk("t5_head", axis_tdata_o, 64'h00000000_00000002);
        idle(17, 1);

        // Large-rate exact sum, then reset with words queued
        do_reset();
        for (int k = 0; k < 4095; k++) step(k == 0, 16'd4095, 1, 16'h8000, 16'd0, 0);
        exp_isum = 32'(-134184960);
        chk("t6_isum", 64'(axis_tdata_o[31:0]), 64'(exp_isum));
        chk("t6_qsum", 64'(axis_tdata_o[63:32]), 64'd0);
        idle(1, 1);
        for (int k = 0; k < 5; k++) step(k == 0, 16'd1, 1, 16'(k), 16'(k), 0);
        chk("t6_queued", 64'(fifo_level_o), 64'd5);
        do_reset();
        chk("t6_rst_tvalid", 64'(axis_tvalid_o), 64'd0);
        chk("t6_rst_level", 64'(fifo_level_o), 64'd0);
        for (int k = 0; k < 9; k++) step(0, 16'd0, 1, 16'd1, 16'd1, 0);
        chk("t6_rate10_9", 64'(fifo_level_o), 64'd0);
        step(0, 16'd0, 1, 16'd1, 16'd1, 0);
        chk("t6_rate10_10", axis_tdata_o, 64'h0000000A_0000000A);
        idle(2, 1);

        // Random traffic: rate loads with junk upper bits, bursts of backpressure
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 24) == 0,
                 {4'($urandom_range(0, 15)), 12'($urandom_range(0, 6))},
                 $urandom_range(0, 3) != 0,
                 16'($urandom), 16'($urandom),
                 ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        end
        idle(20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
